mem_port_arbiter: RTL

- Shares the single-ported unified instruction/data memory of the multi-cycle RISC-V core between two requesters.
  - Port 0 (f_*): instruction fetch.
  - Port 1 (d_*): data load/store.
- Req/ready handshake per port; round-robin on contention.
- Sequences each access through a configurable number of memory cycles; sits between the core's IF/MEM stages and the memory block.

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the core's single-ported unified instruction/data memory.
// Fetch (f_*) and data (d_*) requesters share the memory; round-robin on contention.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ready,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT      = 4'(WAIT_CYCLES - 1);
  localparam logic       FIRST_IS_LAST = (WAIT_CYCLES == 1);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                prio_q;
  logic                gnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   mem_a_q;
  logic [DATA_W-1:0]   mem_wd_q;
  logic                mem_we_q;
  logic                f_ready_q;
  logic                d_ready_q;
  logic [DATA_W-1:0]   f_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                gnt_d;

  // Grant select: 0 = fetch, 1 = data; prio breaks a tie.
  always_comb begin
    gnt_d = 1'b0;
    if (f_req && d_req) begin
      gnt_d = prio_q;
    end else if (d_req) begin
      gnt_d = 1'b1;
    end else begin
      gnt_d = 1'b0;
    end
  end

  // Access sequencer: latch request, hold it on the memory, capture, pulse ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      prio_q    <= 1'b0;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      mem_a_q   <= '0;
      mem_wd_q  <= '0;
      mem_we_q  <= 1'b0;
      f_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      f_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          mem_we_q <= 1'b0;
          if (f_req || d_req) begin
            gnt_q   <= gnt_d;
            we_q    <= gnt_d & d_we;
            mem_a_q <= gnt_d ? d_addr : f_addr;
            if (gnt_d) begin
              mem_wd_q <= d_wdata;
            end else begin
              mem_wd_q <= mem_wd_q;
            end
            // With a single wait cycle the first BUSY cycle is also the write cycle.
            mem_we_q <= gnt_d & d_we & FIRST_IS_LAST;
            cnt_q    <= CNT_INIT;
            prio_q   <= ~gnt_d;
            state_q  <= BUSY;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q    <= cnt_q - 4'd1;
            mem_we_q <= we_q & (cnt_q == 4'd1);
          end else begin
            // Capture and write share this edge, so a store returns the pre-write word.
            mem_we_q <= 1'b0;
            if (gnt_q) begin
              d_rdata_q <= mem_rd;
              d_ready_q <= 1'b1;
            end else begin
              f_rdata_q <= mem_rd;
              f_ready_q <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          mem_we_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          mem_we_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign f_ready = f_ready_q;
  assign d_ready = d_ready_q;
  assign f_rdata = f_rdata_q;
  assign d_rdata = d_rdata_q;
  assign mem_a   = mem_a_q;
  assign mem_wd  = mem_wd_q;
  assign mem_we  = mem_we_q;
  assign busy    = (state_q != IDLE);

endmodule
